spindle_spike_gen: RTL and testbench

Converts the spindle's muscle-level afferent firing rate into a rate-coded spike train. The rate is an IEEE-754 single-precision value in pulses/s, such as Ia_muscle or II_muscle, capped upstream at 100000.0. The block sits directly downstream of the spindle model and feeds the motoneuron/spike-counter stages. It holds the rate as a saturated integer and integrates it in a phase accumulator on each simulation tick. It emits one-cycle spike pulses, applies an optional refractory period and keeps a running spike count.

---
 rtl/spindle_spike_gen.sv | 92 +++++++++
 tb/tb_spindle_spike_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spindle_spike_gen.sv
// Rate-coded spike generator: converts an IEEE-754 firing rate to a saturated
// integer and integrates it per tick in a phase accumulator with optional refractory.
module spindle_spike_gen #(
    parameter int unsigned THRESH        = 1000,
    parameter int unsigned REFRACT_TICKS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rate,
    input  logic        rate_valid,
    input  logic        tick,
    input  logic        en,
    output logic        spike,
    output logic [31:0] spike_count,
    output logic [16:0] rate_int
);

    localparam logic [32:0] THRESH_W  = 33'(THRESH);
    localparam logic [31:0] RESID_MAX = 32'(THRESH - 1);
    localparam logic [7:0]  REFR_W    = 8'(REFRACT_TICKS);

    logic [16:0] rate_q, rate_d;
    logic [31:0] acc_q, acc_d;
    logic [7:0]  refr_cnt_q, refr_cnt_d;
    logic [31:0] count_q, count_d;
    logic        spike_q, spike_d;

    logic [7:0]  exp_f;
    logic [23:0] mant;
    logic [4:0]  shamt;
    logic [16:0] conv;

    // Float to saturated integer; in-range exponents give shifts of 7..23.
    always_comb begin
        exp_f = rate[30:23];
        mant  = {1'b1, rate[22:0]};
        shamt = 5'(8'd150 - exp_f);
        conv  = 17'(mant >> shamt);
        if (rate[31] || exp_f < 8'd127) begin
            conv = '0;
        end else if (exp_f >= 8'd144) begin
            conv = '1;
        end
    end

    logic [32:0] sum;
    logic [32:0] resid;

    always_comb begin
        sum        = {1'b0, acc_q} + {16'b0, rate_q};
        resid      = sum - THRESH_W;
        rate_d     = rate_valid ? conv : rate_q;
        acc_d      = acc_q;
        refr_cnt_d = refr_cnt_q;
        count_d    = count_q;
        spike_d    = 1'b0;
        if (tick && en) begin
            if (refr_cnt_q != 8'd0) begin
                refr_cnt_d = refr_cnt_q - 8'd1;
            end else if (sum >= THRESH_W) begin
                spike_d    = 1'b1;
                count_d    = count_q + 32'd1;
                refr_cnt_d = REFR_W;
                // Residue clamp keeps acc below THRESH so one tick yields at most one spike.
                acc_d      = (resid >= {1'b0, RESID_MAX}) ? RESID_MAX : resid[31:0];
            end else begin
                acc_d = sum[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q     <= '0;
            acc_q      <= '0;
            refr_cnt_q <= '0;
            count_q    <= '0;
            spike_q    <= 1'b0;
        end else begin
            rate_q     <= rate_d;
            acc_q      <= acc_d;
            refr_cnt_q <= refr_cnt_d;
            count_q    <= count_d;
            spike_q    <= spike_d;
        end
    end

    assign spike       = spike_q;
    assign spike_count = count_q;
    assign rate_int    = rate_q;

endmodule

// File: tb/tb_spindle_spike_gen.sv
// Directed bench for spindle_spike_gen: one instance without refractory,
// one with a two-tick refractory period, sharing the same stimulus.
module tb_spindle_spike_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rate = '0;
    logic        rate_valid = 1'b0;
    logic        tick = 1'b0;
    logic        en = 1'b1;

    logic        spike_r0, spike_r2;
    logic [31:0] count_r0, count_r2;
    logic [16:0] rint_r0, rint_r2;

    int checks = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    spindle_spike_gen #(.THRESH(1000), .REFRACT_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .rate(rate), .rate_valid(rate_valid),
        .tick(tick), .en(en), .spike(spike_r0), .spike_count(count_r0), .rate_int(rint_r0)
    );

    spindle_spike_gen #(.THRESH(1000), .REFRACT_TICKS(2)) dut2 (
        .clk(clk), .reset(reset), .rate(rate), .rate_valid(rate_valid),
        .tick(tick), .en(en), .spike(spike_r2), .spike_count(count_r2), .rate_int(rint_r2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_rate(input logic [31:0] r);
        @(negedge clk);
        rate = r;
        rate_valid = 1'b1;
        @(posedge clk);
        #1;
        rate_valid = 1'b0;
    endtask

    task automatic do_tick(input logic en_v, input logic exp_spike, input bit use_r2, input string tag);
        @(negedge clk);
        tick = 1'b1;
        en = en_v;
        exp_q.push_back(exp_spike);
        @(posedge clk);
        #1;
        tick = 1'b0;
        en = 1'b1;
        chk(tag, use_r2 ? 32'(spike_r2) : 32'(spike_r0), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] conv_in [6];
        logic [31:0] conv_exp [6];
        conv_in  = '{32'h447A0000, 32'h3F000000, 32'hC2C80000, 32'h47C35000, 32'h49742400, 32'h7F800000};
        conv_exp = '{32'd1000, 32'd0, 32'd0, 32'd100000, 32'd131071, 32'd131071};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_spike", 32'(spike_r0), 32'd0);
        chk("reset_count", count_r0, 32'd0);
        chk("reset_rate_int", 32'(rint_r0), 32'd0);

        // Float conversion
        for (int i = 0; i < 6; i++) begin
            set_rate(conv_in[i]);
            chk($sformatf("conv_%0d", i), 32'(rint_r0), conv_exp[i]);
        end

        // Periodic firing at 250 pps: spikes on every 4th tick
        do_reset();
        set_rate(32'h437A0000);
        chk("rate_250", 32'(rint_r0), 32'd250);
        for (int t = 1; t <= 12; t++) begin
            do_tick(1'b1, (t % 4) == 0, 1'b0, $sformatf("p250_tick%0d", t));
        end
        chk("p250_count", count_r0, 32'd3);

        // 1000 pps: spike every tick, then the pulse drops after one cycle
        set_rate(32'h447A0000);
        for (int t = 1; t <= 4; t++) begin
            do_tick(1'b1, 1'b1, 1'b0, $sformatf("p1000_tick%0d", t));
        end
        chk("p1000_count", count_r0, 32'd7);
        @(posedge clk);
        #1;
        chk("pulse_width", 32'(spike_r0), 32'd0);

        // Saturation and residue clamp
        do_reset();
        set_rate(32'h49742400);
        for (int t = 1; t <= 5; t++) begin
            do_tick(1'b1, 1'b1, 1'b0, $sformatf("sat_tick%0d", t));
            chk($sformatf("sat_acc%0d", t), dut0.acc_q, 32'd999);
        end
        chk("sat_count", count_r0, 32'd5);

        // Refractory: spikes on ticks 1, 4, 7
        do_reset();
        set_rate(32'h447A0000);
        for (int t = 1; t <= 7; t++) begin
            do_tick(1'b1, (t % 3) == 1, 1'b1, $sformatf("refr_tick%0d", t));
        end
        chk("refr_count", count_r2, 32'd3);

        // Refractory with disabled ticks: ignored ticks do not consume refractory
        do_reset();
        set_rate(32'h447A0000);
        do_tick(1'b1, 1'b1, 1'b1, "refr_en_t1");
        do_tick(1'b0, 1'b0, 1'b1, "refr_en_t2");
        do_tick(1'b0, 1'b0, 1'b1, "refr_en_t3");
        do_tick(1'b1, 1'b0, 1'b1, "refr_en_t4");
        do_tick(1'b1, 1'b0, 1'b1, "refr_en_t5");
        do_tick(1'b1, 1'b1, 1'b1, "refr_en_t6");
        chk("refr_en_count", count_r2, 32'd2);

        // Simultaneous rate update and tick: tick uses the old rate
        do_reset();
        set_rate(32'h437A0000);
        for (int t = 1; t <= 3; t++) begin
            do_tick(1'b1, 1'b0, 1'b0, $sformatf("sim_pre%0d", t));
        end
        chk("sim_acc750", dut0.acc_q, 32'd750);
        @(negedge clk);
        rate = 32'h00000000;
        rate_valid = 1'b1;
        tick = 1'b1;
        exp_q.push_back(1'b1);
        @(posedge clk);
        #1;
        rate_valid = 1'b0;
        tick = 1'b0;
        chk("sim_spike", 32'(spike_r0), 32'(exp_q.pop_front()));
        chk("sim_rate_int", 32'(rint_r0), 32'd0);
        for (int t = 1; t <= 3; t++) begin
            do_tick(1'b1, 1'b0, 1'b0, $sformatf("sim_post%0d", t));
        end

        // Reset mid-refractory with acc=500; reset dominates tick and rate_valid
        do_reset();
        set_rate(32'h44BB8000);
        chk("mid_rate_1500", 32'(rint_r2), 32'd1500);
        do_tick(1'b1, 1'b1, 1'b1, "mid_t1");
        do_tick(1'b1, 1'b0, 1'b1, "mid_t2");
        chk("mid_acc", dut2.acc_q, 32'd500);
        chk("mid_refr", 32'(dut2.refr_cnt_q), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick = 1'b1;
        rate = 32'h447A0000;
        rate_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick = 1'b0;
        rate_valid = 1'b0;
        chk("rst_spike", 32'(spike_r2), 32'd0);
        chk("rst_count", count_r2, 32'd0);
        chk("rst_rate_int", 32'(rint_r2), 32'd0);
        chk("rst_acc", dut2.acc_q, 32'd0);
        chk("rst_refr", 32'(dut2.refr_cnt_q), 32'd0);
        set_rate(32'h447A0000);
        do_tick(1'b1, 1'b1, 1'b1, "rst_first_tick");
        chk("rst_first_count", count_r2, 32'd1);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
